// File: rtl/mem_stage.sv
// mem_stage: word-sized data-memory access stage behind the execute ALU.
// It accepts one instruction when idle. Non-memory instructions pass straight through to writeback.
// An aligned LW or SW is issued on a request/grant/response bus. A misaligned access or a timed-out
// access retires as a writeback beat with the write enable cleared, and sets a sticky error flag.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [31:0]       ex_instr,
  input  logic [31:0]       ex_alu_out,
  input  logic [31:0]       ex_store_data,
  input  logic              ex_dm_enable,
  input  logic              ex_dm_write,
  output logic              dm_req,
  output logic              dm_we,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [31:0]       dm_wdata,
  input  logic              dm_gnt,
  input  logic              dm_rvalid,
  input  logic [31:0]       dm_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              err_misalign,
  output logic              err_timeout
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [4:0]         rd_q, rd_d;
  logic               st_q, st_d;
  logic               wb_valid_q, wb_valid_d;
  logic               wb_we_q, wb_we_d;
  logic [4:0]         wb_rd_q, wb_rd_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic               err_mis_q, err_mis_d;
  logic               err_to_q, err_to_d;

  logic       accept;
  logic       misalign;
  logic       last;
  logic       op_writes;
  logic [4:0] ex_rd;

  assign accept   = ex_valid && (state_q == IDLE);
  assign misalign = (ex_alu_out[1:0] != 2'b00);
  assign last     = (cnt_q == TO_LAST);
  assign ex_rd    = ex_instr[11:7];
  // Only these opcodes produce a register result on the non-memory path.
  assign op_writes = (ex_instr[6:0] == OP_R)   || (ex_instr[6:0] == OP_I) ||
                     (ex_instr[6:0] == OP_LUI) || (ex_instr[6:0] == OP_JAL);

  // Next-state, request latching and writeback beat generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    st_d       = st_q;
    wb_valid_d = 1'b0;
    wb_we_d    = wb_we_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_mis_d  = err_mis_q;
    err_to_d   = err_to_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!ex_dm_enable) begin
            wb_valid_d = 1'b1;
            wb_we_d    = op_writes && (ex_rd != 5'd0);
            wb_rd_d    = ex_rd;
            wb_data_d  = ex_alu_out;
          end else if (misalign) begin
            // The access is dropped without touching the bus.
            wb_valid_d = 1'b1;
            wb_we_d    = 1'b0;
            wb_rd_d    = ex_rd;
            err_mis_d  = 1'b1;
          end else begin
            addr_d  = ex_alu_out[ADDR_W-1:0];
            wdata_d = ex_store_data;
            rd_d    = ex_rd;
            st_d    = ex_dm_write;
            cnt_d   = 8'd0;
            state_d = REQ;
          end
        end
      end
      REQ: begin
        cnt_d = cnt_q + 8'd1;
        if (dm_gnt && st_q) begin
          // A granted store completes; it takes priority over a timeout in the same cycle.
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_rd_d    = rd_q;
          state_d    = IDLE;
        end else if (last) begin
          // A load granted on the last allowed cycle has not completed, so the timeout is taken.
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_rd_d    = rd_q;
          err_to_d   = 1'b1;
          state_d    = IDLE;
        end else if (dm_gnt) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q + 8'd1;
        if (dm_rvalid) begin
          wb_valid_d = 1'b1;
          wb_we_d    = (rd_q != 5'd0);
          wb_rd_d    = rd_q;
          wb_data_d  = dm_rdata;
          state_d    = IDLE;
        end else if (last) begin
          wb_valid_d = 1'b1;
          wb_we_d    = 1'b0;
          wb_rd_d    = rd_q;
          err_to_d   = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers. An asynchronous reset abandons any access that is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      cnt_q      <= 8'd0;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      rd_q       <= 5'd0;
      st_q       <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      err_mis_q  <= 1'b0;
      err_to_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      st_q       <= st_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_mis_q  <= err_mis_d;
      err_to_q   <= err_to_d;
    end
  end

  assign ex_ready     = (state_q == IDLE);
  assign dm_req       = (state_q == REQ);
  assign dm_we        = dm_req && st_q;
  assign dm_addr      = {addr_q[ADDR_W-1:2], 2'b00};
  assign dm_wdata     = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_we        = wb_we_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign err_misalign = err_mis_q;
  assign err_timeout  = err_to_q;

  // Instruction bits above rd and the byte offset of the address are not needed here.
  logic unused_bits;
  assign unused_bits = ^{ex_instr[31:12], addr_q[1:0]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage, built with TIMEOUT=4. The expected values are worked out by hand.
// Inputs are driven and outputs are sampled 1ns after the rising edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [31:0] ex_instr, ex_alu_out, ex_store_data;
  logic        ex_dm_enable, ex_dm_write;
  logic        dm_req, dm_we;
  logic [31:0] dm_addr, dm_wdata;
  logic        dm_gnt, dm_rvalid;
  logic [31:0] dm_rdata;
  logic        wb_valid, wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_misalign, err_timeout;

  int n_tests = 0;
  int n_fail  = 0;

  mem_stage #(.TIMEOUT(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_instr(ex_instr),
    .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_dm_enable(ex_dm_enable), .ex_dm_write(ex_dm_write),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] instr, input logic [31:0] alu, input logic [31:0] sd,
                       input logic en, input logic wr);
    ex_valid = 1'b1; ex_instr = instr; ex_alu_out = alu; ex_store_data = sd;
    ex_dm_enable = en; ex_dm_write = wr;
  endtask

  task automatic idle_in();
    ex_valid = 1'b0; ex_dm_enable = 1'b0; ex_dm_write = 1'b0;
    ex_store_data = 32'hFFFF_FFFF; ex_alu_out = 32'hAAAA_AAA8;
  endtask

  initial begin
    rst = 1'b1; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'd0;
    ex_instr = 32'd0;
    idle_in();
    #3 rst = 1'b0;
    tick(); tick();
    chk("rst_ready",    {31'd0, ex_ready},     32'd1);
    chk("rst_dm_req",   {31'd0, dm_req},       32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid},     32'd0);
    chk("rst_wb_data",  wb_data,               32'd0);
    chk("rst_errs",     {30'd0, err_misalign, err_timeout}, 32'd0);
    @(negedge clk) rst = 1'b1;
    tick();

    // ADD x5: one-cycle passthrough
    issue(32'h0000_02B3, 32'h0000_0007, 32'd0, 1'b0, 1'b0);
    tick();
    idle_in();
    chk("add_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("add_wb_we",    {31'd0, wb_we},    32'd1);
    chk("add_wb_rd",    {27'd0, wb_rd},    32'd5);
    chk("add_wb_data",  wb_data,           32'd7);
    chk("add_ready",    {31'd0, ex_ready}, 32'd1);
    tick();
    chk("pulse_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("hold_wb_data",   wb_data,           32'd7);

    // Branch: no register write
    issue(32'h0000_0263, 32'h0000_0011, 32'd0, 1'b0, 1'b0);
    tick();
    chk("br_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("br_wb_we",    {31'd0, wb_we},    32'd0);
    // ADDI x0: rd zero suppresses the write
    issue(32'h0000_0013, 32'h0000_0022, 32'd0, 1'b0, 1'b0);
    tick();
    chk("x0_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("x0_wb_we",    {31'd0, wb_we},    32'd0);
    // LUI x9 issued back to back
    issue(32'h0000_04B7, 32'h1234_5000, 32'd0, 1'b0, 1'b0);
    tick();
    idle_in();
    chk("lui_wb_we",   {31'd0, wb_we},    32'd1);
    chk("lui_wb_rd",   {27'd0, wb_rd},    32'd9);
    chk("lui_wb_data", wb_data,           32'h1234_5000);
    tick();

    // LW x3 from 0x100: grant in first REQ cycle, data one cycle later
    issue(32'h0000_0183, 32'h0000_0100, 32'd0, 1'b1, 1'b0);
    tick();
    idle_in();
    chk("lw_req",      {31'd0, dm_req},   32'd1);
    chk("lw_we",       {31'd0, dm_we},    32'd0);
    chk("lw_addr",     dm_addr,           32'h0000_0100);
    chk("lw_ready0",   {31'd0, ex_ready}, 32'd0);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("lw_wait_req", {31'd0, dm_req},   32'd0);
    chk("lw_ready1",   {31'd0, ex_ready}, 32'd0);
    chk("lw_no_wb",    {31'd0, wb_valid}, 32'd0);
    dm_rvalid = 1'b1; dm_rdata = 32'hDEAD_BEEF;
    tick();
    dm_rvalid = 1'b0; dm_rdata = 32'd0;
    chk("lw_wb_valid", {31'd0, wb_valid}, 32'd1);
    chk("lw_wb_we",    {31'd0, wb_we},    32'd1);
    chk("lw_wb_rd",    {27'd0, wb_rd},    32'd3);
    chk("lw_wb_data",  wb_data,           32'hDEAD_BEEF);
    chk("lw_ready2",   {31'd0, ex_ready}, 32'd1);
    tick();

    // SW to 0x204: request held 3 cycles, then granted on the last allowed cycle
    issue(32'h0000_0023, 32'h0000_0204, 32'h0000_1234, 1'b1, 1'b1);
    tick();
    idle_in();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sw_req%0d", i),   {31'd0, dm_req}, 32'd1);
      chk($sformatf("sw_we%0d", i),    {31'd0, dm_we},  32'd1);
      chk($sformatf("sw_addr%0d", i),  dm_addr,         32'h0000_0204);
      chk($sformatf("sw_wdata%0d", i), dm_wdata,        32'h0000_1234);
      tick();
    end
    chk("sw_req3", {31'd0, dm_req}, 32'd1);
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("sw_req_drop", {31'd0, dm_req},      32'd0);
    chk("sw_wb_valid", {31'd0, wb_valid},    32'd1);
    chk("sw_wb_we",    {31'd0, wb_we},       32'd0);
    chk("sw_no_tmo",   {31'd0, err_timeout}, 32'd0);
    chk("sw_ready",    {31'd0, ex_ready},    32'd1);
    tick();

    // Misaligned LW at 0x102
    issue(32'h0000_0183, 32'h0000_0102, 32'd0, 1'b1, 1'b0);
    tick();
    idle_in();
    chk("mis_req",      {31'd0, dm_req},       32'd0);
    chk("mis_wb_valid", {31'd0, wb_valid},     32'd1);
    chk("mis_wb_we",    {31'd0, wb_we},        32'd0);
    chk("mis_err",      {31'd0, err_misalign}, 32'd1);
    chk("mis_ready",    {31'd0, ex_ready},     32'd1);
    tick();
    chk("mis_req2",     {31'd0, dm_req},       32'd0);

    // Timeout: LW x6 at 0x300, no grant ever
    issue(32'h0000_0303, 32'h0000_0300, 32'd0, 1'b1, 1'b0);
    tick();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("tmo_req%0d", i), {31'd0, dm_req}, 32'd1);
      tick();
    end
    chk("tmo_req_drop", {31'd0, dm_req},       32'd0);
    chk("tmo_wb_valid", {31'd0, wb_valid},     32'd1);
    chk("tmo_wb_we",    {31'd0, wb_we},        32'd0);
    chk("tmo_err",      {31'd0, err_timeout},  32'd1);
    chk("tmo_ready",    {31'd0, ex_ready},     32'd1);
    chk("mis_sticky",   {31'd0, err_misalign}, 32'd1);
    tick();

    // Reset while in WAIT
    issue(32'h0000_0383, 32'h0000_0400, 32'd0, 1'b1, 1'b0);
    tick();
    idle_in();
    dm_gnt = 1'b1;
    tick();
    dm_gnt = 1'b0;
    chk("rsw_ready0", {31'd0, ex_ready}, 32'd0);
    #2 rst = 1'b0;
    #1;
    chk("rsw_req",      {31'd0, dm_req},   32'd0);
    chk("rsw_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rsw_errs",     {30'd0, err_misalign, err_timeout}, 32'd0);
    @(negedge clk) rst = 1'b1;
    tick();
    chk("rsw_ready1", {31'd0, ex_ready}, 32'd1);
    dm_rvalid = 1'b1; dm_rdata = 32'h5555_AAAA;
    tick();
    dm_rvalid = 1'b0;
    chk("rsw_late_rvalid", {31'd0, wb_valid}, 32'd0);
    chk("rsw_ready2",      {31'd0, ex_ready}, 32'd1);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
